// File: rtl/drawing_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drawing_ctrl_pkg
// Brief    : Shared state encodings, mouse command values and tool limits for
//            the drawing controller.
// Revision : 1.0
// ============================================================================
package drawing_ctrl_pkg;

    localparam logic [3:0] C_ST_IDLE       = 4'd0;
    localparam logic [3:0] C_ST_MOVE       = 4'd1;
    localparam logic [3:0] C_ST_WAIT       = 4'd2;
    localparam logic [3:0] C_ST_CLEAN      = 4'd3;
    localparam logic [3:0] C_ST_DRAW       = 4'd4;
    localparam logic [3:0] C_ST_ERASE      = 4'd5;
    localparam logic [3:0] C_ST_CLEAR_WAIT = 4'd6;
    localparam logic [3:0] C_ST_CLEAR      = 4'd7;
    localparam logic [3:0] C_ST_CMD_SEND   = 4'd8;
    localparam logic [3:0] C_ST_CMD_WAIT   = 4'd9;
    localparam logic [3:0] C_ST_TOOL       = 4'd10;

    typedef enum logic [3:0] {
        ST_IDLE       = C_ST_IDLE,
        ST_MOVE       = C_ST_MOVE,
        ST_WAIT       = C_ST_WAIT,
        ST_CLEAN      = C_ST_CLEAN,
        ST_DRAW       = C_ST_DRAW,
        ST_ERASE      = C_ST_ERASE,
        ST_CLEAR_WAIT = C_ST_CLEAR_WAIT,
        ST_CLEAR      = C_ST_CLEAR,
        ST_CMD_SEND   = C_ST_CMD_SEND,
        ST_CMD_WAIT   = C_ST_CMD_WAIT,
        ST_TOOL       = C_ST_TOOL
    } state_t;

    localparam logic CMD_ENABLE  = 1'b1;
    localparam logic CMD_DISABLE = 1'b0;

    localparam int C_MIN_TOOLS  = 2;
    localparam int C_TOOL_FIRST = 0;

endpackage
`default_nettype wire

// File: rtl/drawing_control_fsm_ext_mouse_cmd_timer.sv
`default_nettype none
// ============================================================================
// Module   : mouse_cmd_timer
// Brief    : Ack-timeout counter and retry counter for mouse commands.
//            Retry counting exists only when MOUSE_CMD_RETRY_EN is defined.
// Revision : 1.0
// ============================================================================
module mouse_cmd_timer #(
    parameter int ACK_TIMEOUT = 2000000,
    parameter int CMD_RETRIES = 3
) (
    input  logic iClk,
    input  logic iReset,
    input  logic i_clr,
    input  logic i_run,
    input  logic i_retry_inc,
    input  logic i_retry_clr,
    output logic o_timeout,
    output logic o_retries_left
);

    localparam int                C_TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(ACK_TIMEOUT - 1);

    logic [C_TO_W-1:0] r_to_cnt;

    // Saturates at the last count so a stalled FSM never wraps back to zero.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_to_cnt <= '0;
        end else if (i_clr) begin
            r_to_cnt <= '0;
        end else if (i_run && (r_to_cnt != C_TO_LAST)) begin
            r_to_cnt <= r_to_cnt + C_TO_W'(1);
        end
    end

    assign o_timeout = i_run && (r_to_cnt == C_TO_LAST);

`ifdef MOUSE_CMD_RETRY_EN
    localparam int C_RT_W = (CMD_RETRIES > 0) ? $clog2(CMD_RETRIES + 1) : 1;

    logic [C_RT_W-1:0] r_retry_cnt;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_retry_cnt <= '0;
        end else if (i_retry_clr) begin
            r_retry_cnt <= '0;
        end else if (i_retry_inc && o_retries_left) begin
            r_retry_cnt <= r_retry_cnt + C_RT_W'(1);
        end
    end

    assign o_retries_left = (r_retry_cnt < C_RT_W'(CMD_RETRIES));
`else
    logic w_unused_retry;
    assign w_unused_retry = i_retry_inc ^ i_retry_clr ^ (CMD_RETRIES != 0);
    assign o_retries_left = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/drawing_control_fsm_ext.sv
`default_nettype none
// ============================================================================
// Module   : drawing_control_fsm_ext
// Brief    : Drawing controller FSM with acknowledged mouse enable/disable
//            commands, frame-delay wait and tool selection.
//            Optional retry of failed commands: MOUSE_CMD_RETRY_EN.
// Revision : 1.0
// ============================================================================
module drawing_control_fsm_ext
    import drawing_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 833333,
    parameter int ACK_TIMEOUT = 2000000,
    parameter int CMD_RETRIES = 3,
    parameter int NUM_TOOLS   = 4,
    parameter int TOOL_W      = $clog2(NUM_TOOLS)
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iBtnL,
    input  logic              iBtnR,
    input  logic              iBtnM,
    input  logic              iMove,
    input  logic              iDone,
    input  logic              iClear,
    input  logic              iTxAck,
    input  logic              iTxErr,
    output logic [3:0]        oState,
    output logic [TOOL_W-1:0] oTool,
    output logic              oEnableMouse,
    output logic              oStartTransmission,
    output logic              oBusy,
    output logic              oCmdFail
);

    localparam int                 C_WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [C_WAIT_W-1:0] C_WAIT_LOAD = C_WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [TOOL_W-1:0]   C_TOOL_LAST = TOOL_W'(NUM_TOOLS - 1);
    localparam logic [TOOL_W-1:0]   C_TOOL_INIT = TOOL_W'(C_TOOL_FIRST);

    state_t              r_state;
    state_t              w_next_state;
    state_t              r_ret_state;
    state_t              w_ret_val;
    logic                r_pend_cmd;
    logic                w_cmd_val;
    logic                r_enable_mouse;
    logic                r_cmd_fail;
    logic [TOOL_W-1:0]   r_tool;
    logic [C_WAIT_W-1:0] r_wait_cnt;

    logic w_load_wait;
    logic w_tool_step;
    logic w_load_cmd;
    logic w_timer_clr;
    logic w_retry_inc;
    logic w_retry_clr;
    logic w_set_fail;
    logic w_timeout;
    logic w_retries_left;

    mouse_cmd_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CMD_RETRIES (CMD_RETRIES)
    ) u_cmd_timer (
        .iClk           (iClk),
        .iReset         (iReset),
        .i_clr          (w_timer_clr),
        .i_run          (r_state == ST_CMD_WAIT),
        .i_retry_inc    (w_retry_inc),
        .i_retry_clr    (w_retry_clr),
        .o_timeout      (w_timeout),
        .o_retries_left (w_retries_left)
    );

    // Reset lands in CMD_SEND so the enable command goes out immediately.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state <= ST_CMD_SEND;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ret_val    = r_ret_state;
        w_cmd_val    = r_pend_cmd;
        w_load_wait  = 1'b0;
        w_tool_step  = 1'b0;
        w_load_cmd   = 1'b0;
        w_timer_clr  = 1'b0;
        w_retry_inc  = 1'b0;
        w_retry_clr  = 1'b0;
        w_set_fail   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iMove) begin
                    w_next_state = ST_MOVE;
                end else if (iBtnL) begin
                    w_next_state = ST_DRAW;
                end else if (iBtnR) begin
                    w_next_state = ST_ERASE;
                end else if (iBtnM) begin
                    w_next_state = ST_TOOL;
                    w_tool_step  = 1'b1;
                end else if (iClear) begin
                    w_next_state = ST_CLEAR_WAIT;
                end
            end
            ST_MOVE: begin
                if (iDone) begin
                    w_next_state = ST_WAIT;
                    w_load_wait  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_next_state = ST_CLEAN;
                end
            end
            ST_CLEAN, ST_DRAW, ST_ERASE: begin
                if (iDone) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_TOOL: begin
                if (!iBtnM) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CLEAR_WAIT: begin
                if (!iClear) begin
                    w_load_cmd   = 1'b1;
                    w_cmd_val    = CMD_DISABLE;
                    w_ret_val    = ST_CLEAR;
                    w_next_state = ST_CMD_SEND;
                end
            end
            ST_CLEAR: begin
                if (iDone) begin
                    w_load_cmd   = 1'b1;
                    w_cmd_val    = CMD_ENABLE;
                    w_ret_val    = ST_IDLE;
                    w_next_state = ST_CMD_SEND;
                end
            end
            ST_CMD_SEND: begin
                w_timer_clr  = 1'b1;
                w_next_state = ST_CMD_WAIT;
            end
            ST_CMD_WAIT: begin
                // Ack wins over a simultaneous error.
                if (iTxAck) begin
                    w_retry_clr  = 1'b1;
                    w_next_state = r_ret_state;
                end else if (iTxErr || w_timeout) begin
                    if (w_retries_left) begin
                        w_retry_inc  = 1'b1;
                        w_next_state = ST_CMD_SEND;
                    end else begin
                        w_set_fail   = 1'b1;
                        w_retry_clr  = 1'b1;
                        w_next_state = r_ret_state;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_ret_state    <= ST_IDLE;
            r_pend_cmd     <= CMD_ENABLE;
            r_enable_mouse <= CMD_ENABLE;
            r_cmd_fail     <= 1'b0;
            r_tool         <= C_TOOL_INIT;
            r_wait_cnt     <= '0;
        end else begin
            if (w_load_cmd) begin
                r_pend_cmd  <= w_cmd_val;
                r_ret_state <= w_ret_val;
            end
            if (r_state == ST_CMD_SEND) begin
                r_enable_mouse <= r_pend_cmd;
            end
            if (w_set_fail) begin
                r_cmd_fail <= 1'b1;
            end
            if (w_tool_step) begin
                r_tool <= (r_tool == C_TOOL_LAST) ? C_TOOL_INIT : r_tool + TOOL_W'(1);
            end
            if (w_load_wait) begin
                r_wait_cnt <= C_WAIT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - C_WAIT_W'(1);
            end
        end
    end

    // The start pulse is gated by reset so it stays low while reset is held.
    assign oStartTransmission = (r_state == ST_CMD_SEND) && !iReset;
    assign oEnableMouse       = (r_state == ST_CMD_SEND) ? r_pend_cmd : r_enable_mouse;
    assign oState             = r_state;
    assign oTool              = r_tool;
    assign oBusy              = (r_state != ST_IDLE);
    assign oCmdFail           = r_cmd_fail;

endmodule
`default_nettype wire

// File: tb/tb_drawing_control_fsm_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_drawing_control_fsm_ext
// Brief    : Directed self-checking bench for drawing_control_fsm_ext.
// Revision : 1.0
// ============================================================================
module tb_drawing_control_fsm_ext;

    localparam int WAIT_CYCLES = 4;
    localparam int ACK_TIMEOUT = 8;
    localparam int CMD_RETRIES = 2;
    localparam int NUM_TOOLS   = 3;
    localparam int TOOL_W      = 2;
`ifdef MOUSE_CMD_RETRY_EN
    localparam int EXP_ATTEMPTS = CMD_RETRIES + 1;
`else
    localparam int EXP_ATTEMPTS = 1;
`endif
    // One CMD_SEND cycle plus ACK_TIMEOUT cycles in CMD_WAIT per attempt.
    localparam int ATTEMPT_CYC = 1 + ACK_TIMEOUT;

    logic              iClk   = 1'b0;
    logic              iReset = 1'b1;
    logic              iBtnL  = 1'b0;
    logic              iBtnR  = 1'b0;
    logic              iBtnM  = 1'b0;
    logic              iMove  = 1'b0;
    logic              iDone  = 1'b0;
    logic              iClear = 1'b0;
    logic              iTxAck = 1'b0;
    logic              iTxErr = 1'b0;
    logic [3:0]        oState;
    logic [TOOL_W-1:0] oTool;
    logic              oEnableMouse;
    logic              oStartTransmission;
    logic              oBusy;
    logic              oCmdFail;

    drawing_control_fsm_ext #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CMD_RETRIES (CMD_RETRIES),
        .NUM_TOOLS   (NUM_TOOLS),
        .TOOL_W      (TOOL_W)
    ) dut (
        .iClk               (iClk),
        .iReset             (iReset),
        .iBtnL              (iBtnL),
        .iBtnR              (iBtnR),
        .iBtnM              (iBtnM),
        .iMove              (iMove),
        .iDone              (iDone),
        .iClear             (iClear),
        .iTxAck             (iTxAck),
        .iTxErr             (iTxErr),
        .oState             (oState),
        .oTool              (oTool),
        .oEnableMouse       (oEnableMouse),
        .oStartTransmission (oStartTransmission),
        .oBusy              (oBusy),
        .oCmdFail           (oCmdFail)
    );

    always #5 iClk = ~iClk;

    int   err_cnt        = 0;
    int   chk_cnt        = 0;
    int   cyc            = 0;
    int   pulse_cnt      = 0;
    int   pulse_cyc_last = 0;
    int   pulse_cyc_prev = 0;
    logic pulse_en_last  = 1'b0;

    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (oStartTransmission) begin
            pulse_cnt      <= pulse_cnt + 1;
            pulse_cyc_prev <= pulse_cyc_last;
            pulse_cyc_last <= cyc;
            pulse_en_last  <= oEnableMouse;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] target, input int budget, output int n);
        n = 0;
        while ((oState !== target) && (n < budget)) begin
            step();
            n++;
        end
    endtask

    initial begin
        int p0;
        int n;
        logic [TOOL_W-1:0] exp_tool [4];
        exp_tool[0] = 2'd1;
        exp_tool[1] = 2'd2;
        exp_tool[2] = 2'd0;
        exp_tool[3] = 2'd1;

        // Reset values
        step();
        step();
        check("rst_state", oState, 4'd8);
        check("rst_start", oStartTransmission, 1'b0);
        check("rst_en", oEnableMouse, 1'b1);
        check("rst_tool", oTool, 0);
        check("rst_fail", oCmdFail, 1'b0);
        check("rst_busy", oBusy, 1'b1);

        // Power-up enable command acknowledged
        p0 = pulse_cnt;
        iReset = 1'b0;
        step();
        check("pu_cmd_wait", oState, 4'd9);
        check("pu_pulses", pulse_cnt - p0, 1);
        check("pu_pulse_en", pulse_en_last, 1'b1);
        step();
        step();
        iTxAck = 1'b1;
        step();
        iTxAck = 1'b0;
        check("pu_idle", oState, 4'd0);
        check("pu_busy", oBusy, 1'b0);

        // Move / wait / clean
        iMove = 1'b1;
        step();
        iMove = 1'b0;
        check("mv_move", oState, 4'd1);
        repeat (4) step();
        check("mv_hold", oState, 4'd1);
        iDone = 1'b1;
        step();
        iDone = 1'b0;
        check("mv_wait", oState, 4'd2);
        n = 0;
        while ((oState == 4'd2) && (n < 50)) begin
            step();
            n++;
        end
        check("mv_wait_len", n, WAIT_CYCLES);
        check("mv_clean", oState, 4'd3);
        iDone = 1'b1;
        step();
        iDone = 1'b0;
        check("mv_idle", oState, 4'd0);

        // Clear sequence: disable, clear, enable
        p0 = pulse_cnt;
        iClear = 1'b1;
        step();
        check("cl_wait", oState, 4'd6);
        repeat (9) step();
        check("cl_hold", oState, 4'd6);
        check("cl_no_pulse", pulse_cnt - p0, 0);
        iClear = 1'b0;
        step();
        check("cl_send", oState, 4'd8);
        check("cl_start", oStartTransmission, 1'b1);
        check("cl_en_dis", oEnableMouse, 1'b0);
        step();
        check("cl_cmd_wait", oState, 4'd9);
        check("cl_en_held", oEnableMouse, 1'b0);
        check("cl_start_off", oStartTransmission, 1'b0);
        iTxAck = 1'b1;
        step();
        iTxAck = 1'b0;
        check("cl_clear", oState, 4'd7);
        iDone = 1'b1;
        step();
        iDone = 1'b0;
        check("cl_send2", oState, 4'd8);
        check("cl_en_ena", oEnableMouse, 1'b1);
        step();
        iTxAck = 1'b1;
        step();
        iTxAck = 1'b0;
        check("cl_idle", oState, 4'd0);
        check("cl_pulses", pulse_cnt - p0, 2);
        check("cl_en_final", oEnableMouse, 1'b1);

        // Tool cycling
        for (int i = 0; i < 4; i++) begin
            iBtnM = 1'b1;
            step();
            step();
            iBtnM = 1'b0;
            step();
            check("tool_idx", oTool, exp_tool[i]);
            check("tool_idle", oState, 4'd0);
        end
        iBtnM = 1'b1;
        repeat (20) step();
        check("tool_hold_st", oState, 4'd10);
        iBtnM = 1'b0;
        step();
        check("tool_hold_idx", oTool, 2'd2);

        // IDLE priority and draw/erase
        iBtnL = 1'b1;
        iMove = 1'b1;
        step();
        iBtnL = 1'b0;
        iMove = 1'b0;
        check("pri_move", oState, 4'd1);
        iDone = 1'b1;
        step();
        iDone = 1'b0;
        wait_state(4'd3, 20, n);
        check("pri_clean", oState, 4'd3);
        iDone = 1'b1;
        step();
        iDone = 1'b0;
        iBtnL = 1'b1;
        step();
        iBtnL = 1'b0;
        check("draw", oState, 4'd4);
        iDone = 1'b1;
        step();
        iDone = 1'b0;
        check("draw_idle", oState, 4'd0);
        iBtnR = 1'b1;
        iBtnM = 1'b1;
        step();
        iBtnR = 1'b0;
        iBtnM = 1'b0;
        check("erase", oState, 4'd5);
        check("erase_tool", oTool, 2'd2);
        iDone = 1'b1;
        step();
        iDone = 1'b0;

        // Ack and error together count as ack
        iClear = 1'b1;
        step();
        iClear = 1'b0;
        step();
        step();
        check("ae_cmd_wait", oState, 4'd9);
        iTxAck = 1'b1;
        iTxErr = 1'b1;
        step();
        iTxAck = 1'b0;
        iTxErr = 1'b0;
        check("ae_clear", oState, 4'd7);
        check("ae_nofail", oCmdFail, 1'b0);
        iDone = 1'b1;
        step();
        iDone = 1'b0;
        step();
        iTxAck = 1'b1;
        step();
        iTxAck = 1'b0;
        check("ae_idle", oState, 4'd0);

        // No acknowledge after reset
        iReset = 1'b1;
        #1;
        check("nk_rst_state", oState, 4'd8);
        check("nk_rst_tool", oTool, 0);
        step();
        p0 = pulse_cnt;
        iReset = 1'b0;
        wait_state(4'd0, 100, n);
        check("nk_idle", oState, 4'd0);
        check("nk_cycles", n, ATTEMPT_CYC * EXP_ATTEMPTS);
        check("nk_pulses", pulse_cnt - p0, EXP_ATTEMPTS);
        check("nk_fail", oCmdFail, 1'b1);
        check("nk_en", oEnableMouse, 1'b1);
`ifdef MOUSE_CMD_RETRY_EN
        check("nk_spacing", pulse_cyc_last - pulse_cyc_prev, ATTEMPT_CYC);
`endif
        step();
        check("nk_fail_sticky", oCmdFail, 1'b1);

        // Reset in the middle of a command
        iClear = 1'b1;
        step();
        iClear = 1'b0;
        step();
        step();
        check("mr_cmd_wait", oState, 4'd9);
        #2;
        iReset = 1'b1;
        #1;
        check("mr_state", oState, 4'd8);
        check("mr_fail", oCmdFail, 1'b0);
        check("mr_start", oStartTransmission, 1'b0);
        step();
        iReset = 1'b0;
        step();
        iTxAck = 1'b1;
        step();
        iTxAck = 1'b0;
        check("mr_idle", oState, 4'd0);
        check("mr_fail2", oCmdFail, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
